// File: rtl/interrupt_sequencer_if.sv
// Purpose : bundles the interrupt sequencer's request, control and status signals.
// Latency : n/a (wires only).
// Backpressure: none; the master drives requests/opcode/strobes, the slave drives status.
// Ports (master view):
//   out irq_req, op, mask_we, mask_wdata, gie_we, gie_wdata
//   in  interrupt, irq_id, irq_vector, in_service, pending
interface interrupt_sequencer_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_req;
    logic [5:0]         op;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               gie_we;
    logic               gie_wdata;
    logic               interrupt;
    logic [2:0]         irq_id;
    logic [15:0]        irq_vector;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq_req, op, mask_we, mask_wdata, gie_we, gie_wdata,
        input  interrupt, irq_id, irq_vector, in_service, pending
    );

    modport slave (
        input  irq_req, op, mask_we, mask_wdata, gie_we, gie_wdata,
        output interrupt, irq_id, irq_vector, in_service, pending
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Purpose : latches edge-triggered IRQs, masks/prioritises them and pulses the jump unit.
// Latency : pulse is combinational in the cycle pending&mask&gie holds outside flow control.
// Backpressure: one service at a time; new requests stay pending until the ISR's ret.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   bus (slave)  : irq_req/op/mask/gie inputs; interrupt, irq_id, irq_vector,
//                  in_service and pending outputs
module interrupt_sequencer #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = 16'hF000,
    parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
    input  logic                 clk,
    input  logic                 reset,
    interrupt_sequencer_if.slave bus
);

    localparam logic [5:0] OP_JV  = 6'b011100;
    localparam logic [5:0] OP_JNV = 6'b011101;
    localparam logic [5:0] OP_JZ  = 6'b011110;
    localparam logic [5:0] OP_JNZ = 6'b011111;
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD0,
        HOLD1,
        SERVICE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_gie;
    logic [2:0]         r_irq_id;
    logic               r_in_service;

    logic               w_fc;
    logic               w_ret;
    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_fire_ok;
    logic [2:0]         w_win_idx;
    logic [NUM_IRQ-1:0] w_win_onehot;
    logic               w_interrupt;
    logic               w_ret_done;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [15:0]        w_id_ext;
    logic [15:0]        w_irq_vector;

    // Opcode decode: firing while a jump/ret is in decode would corrupt the
    // return address the jump unit is about to save.
    always_comb begin
        w_fc = 1'b0;
        case (bus.op)
            OP_JV, OP_JNV, OP_JZ, OP_JNZ, OP_JMP, OP_RET: w_fc = 1'b1;
            default:                                      w_fc = 1'b0;
        endcase
    end

    assign w_ret      = (bus.op == OP_RET);
    assign w_eligible = r_pending & r_mask;
    assign w_fire_ok  = r_gie & (|w_eligible) & ~w_fc;

    // Fixed priority: scan downwards so the lowest eligible index wins.
    always_comb begin
        w_win_idx    = 3'd0;
        w_win_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx       = 3'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and pulse generation. The pulse is suppressed while reset
    // is asserted so a reset cycle can never launch an interrupt.
    always_comb begin
        w_next_state = r_state;
        w_interrupt  = 1'b0;
        w_ret_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire_ok && !reset) begin
                    w_interrupt  = 1'b1;
                    w_next_state = HOLD0;
                end
            end
            HOLD0:   w_next_state = HOLD1;
            HOLD1:   w_next_state = SERVICE;
            SERVICE: begin
                if (w_ret) begin
                    w_ret_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // A new rising edge beats the winner clear on the same bit.
    assign w_set = bus.irq_req & ~r_irq_prev;
    assign w_clr = w_interrupt ? w_win_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Load the current level so requests held across reset are not
            // seen as fresh edges.
            r_irq_prev   <= bus.irq_req;
            r_pending    <= '0;
            r_mask       <= '0;
            r_gie        <= 1'b0;
            r_irq_id     <= 3'd0;
            r_in_service <= 1'b0;
        end else begin
            r_irq_prev <= bus.irq_req;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (bus.mask_we) r_mask <= bus.mask_wdata;
            if (bus.gie_we)  r_gie  <= bus.gie_wdata;
            if (w_interrupt) begin
                r_irq_id     <= w_win_idx;
                r_in_service <= 1'b1;
            end else if (w_ret_done) begin
                r_in_service <= 1'b0;
            end
        end
    end

    // 16-bit product and sum; wrap-around is intended.
    assign w_id_ext     = {13'd0, r_irq_id};
    assign w_irq_vector = VEC_BASE + w_id_ext * VEC_STRIDE;

    assign bus.interrupt  = w_interrupt;
    assign bus.irq_id     = r_irq_id;
    assign bus.irq_vector = w_irq_vector;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;

endmodule
